// File: rtl/lfsr_decrypt_ctrl_if.sv
// Signal bundle between the decrypt controller and its datapath
// (dat_mem plus the six-LFSR bank), with the host start/status lines.
interface lfsr_decrypt_ctrl_if;
  logic        start;
  logic [7:0]  data_out;
  logic [35:0] lfsr_state;
  logic [7:0]  raddr;
  logic [7:0]  waddr;
  logic        wr_en;
  logic [7:0]  data_in;
  logic        load_lfsr;
  logic        lfsr_en;
  logic [2:0]  tap_sel;
  logic [3:0]  pad_ct;
  logic        busy;
  logic        done;
  logic        err;

  // Environment side: host, memory and LFSR bank
  modport master (
    output start, data_out, lfsr_state,
    input  raddr, waddr, wr_en, data_in, load_lfsr, lfsr_en,
           tap_sel, pad_ct, busy, done, err
  );

  // Controller side
  modport slave (
    input  start, data_out, lfsr_state,
    output raddr, waddr, wr_en, data_in, load_lfsr, lfsr_en,
           tap_sel, pad_ct, busy, done, err
  );
endinterface

// File: rtl/lfsr_decrypt_ctrl.sv
// Sequencer for LFSR stream decryption: seeds six candidate LFSRs from the
// first ciphertext symbol, trains them over the preamble, identifies the
// tap pattern, then streams plaintext to memory with leading pads moved
// to the tail of a fixed-length output block.
module lfsr_decrypt_ctrl #(
  parameter int unsigned SRC_BASE = 64,
  parameter int unsigned DST_BASE = 0,
  parameter int unsigned MSG_LEN  = 64,
  parameter int unsigned PRE_LEN  = 7,
  parameter logic [7:0]  PAD      = 8'h5F,
  parameter logic [5:0]  KEY      = 6'h1F,
  parameter int unsigned MAX_PAD  = 15
) (
  input logic                 clk,
  input logic                 init_n,
  lfsr_decrypt_ctrl_if.slave  bus
);

  localparam int unsigned CW = 9;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TRAIN, S_DECRYPT, S_FILL, S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_c;
  logic [7:0]    r_waddr;
  logic [2:0]    r_tap_sel;
  logic [3:0]    r_pad_ct;
  logic          r_err;
  logic          r_skip;

  logic [5:0]    w_st [8];
  logic [5:0]    w_ks;
  logic [5:0]    w_sym;
  logic [7:0]    w_dec;
  logic [7:0]    w_rd_addr;
  logic [2:0]    w_match_ct;
  logic [2:0]    w_match_idx;
  logic          w_drop;
  logic          w_last;

  logic [7:0]    w_raddr;
  logic          w_wr_en;
  logic [7:0]    w_data_in;
  logic          w_load_lfsr;
  logic          w_lfsr_en;
  logic          w_busy;
  logic          w_done;

  // Unpack the LFSR bank; unused slots 6/7 read as zero
  always_comb begin
    for (int i = 0; i < 8; i++) w_st[i] = '0;
    for (int i = 0; i < 6; i++) w_st[i] = bus.lfsr_state[6*i +: 6];
  end

  assign w_ks      = w_st[r_tap_sel];
  assign w_sym     = bus.data_out[5:0] ^ KEY;
  assign w_dec     = bus.data_out ^ {2'b00, w_ks};
  assign w_rd_addr = 8'(SRC_BASE) + r_c[7:0] - 8'd1;
  assign w_last    = (r_c == CW'(MSG_LEN));
  assign w_drop    = r_skip && (w_dec == PAD) && (r_pad_ct < 4'(MAX_PAD));

  // Count LFSR candidates whose state matches the current keystream symbol
  always_comb begin
    w_match_ct  = '0;
    w_match_idx = '0;
    for (int i = 0; i < 6; i++) begin
      if (w_st[i] == w_sym) begin
        w_match_ct  = w_match_ct + 3'd1;
        w_match_idx = 3'(i);
      end
    end
  end

  // Same-cycle memory/LFSR controls decoded from state
  always_comb begin
    w_raddr     = 8'(SRC_BASE);
    w_wr_en     = 1'b0;
    w_data_in   = w_dec;
    w_load_lfsr = 1'b0;
    w_lfsr_en   = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:    w_busy = 1'b0;
      S_LOAD:    w_load_lfsr = 1'b1;
      S_TRAIN: begin
        w_raddr   = w_rd_addr;
        w_lfsr_en = 1'b1;
      end
      S_DECRYPT: begin
        w_raddr   = w_rd_addr;
        w_lfsr_en = 1'b1;
        w_wr_en   = !w_drop;
      end
      S_FILL: begin
        w_wr_en   = 1'b1;
        w_data_in = PAD;
      end
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // Sequencer state, counters and held status
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state   <= S_IDLE;
      r_c       <= '0;
      r_waddr   <= 8'(DST_BASE);
      r_tap_sel <= '0;
      r_pad_ct  <= '0;
      r_err     <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) r_state <= S_LOAD;
        S_LOAD: begin
          r_c      <= CW'(1);
          r_pad_ct <= '0;
          r_err    <= 1'b0;
          r_waddr  <= 8'(DST_BASE);
          r_skip   <= 1'b1;
          r_state  <= S_TRAIN;
        end
        S_TRAIN: begin
          r_c <= r_c + CW'(1);
          if (r_c == CW'(PRE_LEN)) begin
            if (w_match_ct == 3'd1) begin
              r_tap_sel <= w_match_idx;
              r_state   <= S_DECRYPT;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DECRYPT: begin
          r_c <= r_c + CW'(1);
          if (w_drop) begin
            r_pad_ct <= r_pad_ct + 4'd1;
          end else begin
            r_skip  <= 1'b0;
            r_waddr <= r_waddr + 8'd1;
          end
          if (w_last) begin
            r_c     <= CW'(1);
            r_state <= (w_drop || (r_pad_ct != 4'd0)) ? S_FILL : S_DONE;
          end
        end
        S_FILL: begin
          r_waddr <= r_waddr + 8'd1;
          r_c     <= r_c + CW'(1);
          if (r_c == CW'(r_pad_ct)) r_state <= S_DONE;
        end
        S_DONE: if (!bus.start) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.raddr     = w_raddr;
  assign bus.waddr     = r_waddr;
  assign bus.wr_en     = w_wr_en;
  assign bus.data_in   = w_data_in;
  assign bus.load_lfsr = w_load_lfsr;
  assign bus.lfsr_en   = w_lfsr_en;
  assign bus.tap_sel   = r_tap_sel;
  assign bus.pad_ct    = r_pad_ct;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_lfsr_decrypt_ctrl.sv
// Bench for lfsr_decrypt_ctrl: models dat_mem and the six-LFSR bank,
// builds randomized messages and predicts tap, pad count, latency and the
// output block from the message-level rules.
module tb_lfsr_decrypt_ctrl;

  localparam int SRC  = 64;
  localparam int DST  = 0;
  localparam int MLEN = 64;
  localparam int PLEN = 7;
  localparam int MAXP = 15;
  localparam int OLEN = MLEN - PLEN;
  localparam logic [7:0] PAD = 8'h5F;
  localparam logic [5:0] KEY = 6'h1F;

  logic clk = 1'b0;
  logic init_n;
  always #5 clk = ~clk;

  lfsr_decrypt_ctrl_if bus();

  lfsr_decrypt_ctrl #(
    .SRC_BASE(SRC), .DST_BASE(DST), .MSG_LEN(MLEN), .PRE_LEN(PLEN),
    .PAD(PAD), .KEY(KEY), .MAX_PAD(MAXP)
  ) dut (
    .clk(clk),
    .init_n(init_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Environment state
  logic [7:0] src_mem [256];
  logic [7:0] dst_mem [256];
  logic [5:0] lf [6];
  logic       clr = 1'b0;
  int         cyc = 0;
  int         n_wr = 0;
  int         n_load = 0;
  int         first_wr = -1;
  int         addr_bad = 0;

  // Expected results of the current message
  bit         exp_err;
  logic [2:0] exp_tap;
  logic [3:0] exp_pad;
  logic [7:0] exp_out [OLEN];
  logic [2:0] held_tap = 3'd0;

  function automatic logic [5:0] tap_of(input int t);
    case (t)
      0: return 6'h21;
      1: return 6'h2D;
      2: return 6'h30;
      3: return 6'h33;
      4: return 6'h36;
      default: return 6'h39;
    endcase
  endfunction

  function automatic logic [5:0] step(input logic [5:0] s, input int t);
    return {s[4:0], ^(s & tap_of(t))};
  endfunction

  always_comb bus.data_out = src_mem[bus.raddr];
  assign bus.lfsr_state = {lf[5], lf[4], lf[3], lf[2], lf[1], lf[0]};

  // Memory write port, LFSR bank and activity counters
  always @(posedge clk) begin
    if (clr) begin
      for (int a = 0; a < 256; a++) dst_mem[a] <= 8'hAA;
      n_wr = 0;
      first_wr = -1;
      addr_bad = 0;
    end else if (bus.wr_en) begin
      if (bus.waddr !== 8'(DST + n_wr)) addr_bad = addr_bad + 1;
      if (first_wr < 0) first_wr = cyc;
      dst_mem[bus.waddr] <= bus.data_in;
      n_wr = n_wr + 1;
    end
    if (bus.load_lfsr) begin
      n_load = n_load + 1;
      for (int i = 0; i < 6; i++) lf[i] <= bus.data_out[5:0] ^ KEY;
    end else if (bus.lfsr_en) begin
      for (int i = 0; i < 6; i++) lf[i] <= step(lf[i], i);
    end
    cyc = cyc + 1;
  end

  // Build a message (preamble + extra pads + payload) and predict the result
  task automatic build(input logic [5:0] seed, input int t, input int nextra,
                       input int corrupt_bit);
    logic [7:0] pt [MLEN];
    logic [7:0] ct [MLEN];
    logic [5:0] ks [6][MLEN];
    logic [7:0] dq [$];
    logic [5:0] s;
    int nm, lead, o;
    for (int k = 0; k < MLEN; k++) begin
      if (k < PLEN + nextra) pt[k] = PAD;
      else if (k == PLEN + nextra) begin
        pt[k] = 8'($urandom_range(0, 255));
        if (pt[k] == PAD) pt[k] = 8'h41;
      end else if ($urandom_range(0, 7) == 0) pt[k] = PAD;
      else pt[k] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 6; i++) begin
      s = seed;
      for (int k = 0; k < MLEN; k++) begin
        ks[i][k] = s;
        s = step(s, i);
      end
    end
    for (int k = 0; k < MLEN; k++) begin
      ct[k] = pt[k] ^ {2'b00, ks[t][k]};
      if (k == PLEN - 1 && corrupt_bit >= 0) ct[k] = ct[k] ^ 8'(1 << corrupt_bit);
      src_mem[SRC + k] = ct[k];
    end
    nm = 0;
    exp_tap = held_tap;
    for (int i = 0; i < 6; i++) begin
      if (ks[i][PLEN-1] == (ct[PLEN-1][5:0] ^ KEY)) begin
        nm++;
        exp_tap = 3'(i);
      end
    end
    exp_err = (nm != 1);
    if (exp_err) exp_tap = held_tap;
    exp_pad = 4'd0;
    if (!exp_err) begin
      dq = {};
      for (int k = PLEN; k < MLEN; k++) dq.push_back(ct[k] ^ {2'b00, ks[exp_tap][k]});
      lead = 0;
      while (lead < MAXP && dq[lead] == PAD) lead++;
      exp_pad = 4'(lead);
      o = 0;
      for (int j = lead; j < OLEN; j++) begin
        exp_out[o] = dq[j];
        o++;
      end
      for (int j = 0; j < lead; j++) begin
        exp_out[o] = PAD;
        o++;
      end
    end
  endtask

  // Run one pass on the current message and check every outcome
  task automatic run_pass(input string name, input bit hold);
    int cnt, st, lat, exp_lat, base_load, exp_wr;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    base_load = n_load;
    st = cyc;
    bus.start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.done !== 1'b1 && cnt < 400);
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: done not seen within %0d cycles (done=%b)", name, cnt, bus.done);
      bus.start = 1'b0;
      return;
    end
    lat = cnt - 1;
    exp_lat = exp_err ? (1 + PLEN) : (MLEN + 1 + int'(exp_pad));
    exp_wr  = exp_err ? 0 : OLEN;
    n_cmp++;
    if (lat !== exp_lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    n_cmp++;
    if (bus.err !== exp_err) begin n_bad++; $display("FAIL %s err: got %b want %b", name, bus.err, exp_err); end
    n_cmp++;
    if (bus.tap_sel !== exp_tap) begin n_bad++; $display("FAIL %s tap_sel: got %0d want %0d", name, bus.tap_sel, exp_tap); end
    n_cmp++;
    if (bus.pad_ct !== exp_pad) begin n_bad++; $display("FAIL %s pad_ct: got %0d want %0d", name, bus.pad_ct, exp_pad); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s busy in done: got %b want 0", name, bus.busy); end
    n_cmp++;
    if (n_wr !== exp_wr) begin n_bad++; $display("FAIL %s write count: got %0d want %0d", name, n_wr, exp_wr); end
    n_cmp++;
    if (addr_bad !== 0) begin n_bad++; $display("FAIL %s write order: %0d out-of-sequence addresses want 0", name, addr_bad); end
    n_cmp++;
    if (n_load - base_load !== 1) begin n_bad++; $display("FAIL %s loads: got %0d want 1", name, n_load - base_load); end
    if (!exp_err) begin
      n_cmp++;
      if (first_wr - st !== PLEN + 2 + int'(exp_pad)) begin
        n_bad++;
        $display("FAIL %s first write: got cycle %0d want %0d", name, first_wr - st, PLEN + 2 + int'(exp_pad));
      end
      for (int j = 0; j < OLEN; j++) begin
        n_cmp++;
        if (dst_mem[DST + j] !== exp_out[j]) begin
          n_bad++;
          $display("FAIL %s mem[%0d]: got %h want %h", name, DST + j, dst_mem[DST + j], exp_out[j]);
        end
      end
      held_tap = exp_tap;
    end
    n_cmp++;
    if (dst_mem[DST + OLEN] !== 8'hAA) begin
      n_bad++;
      $display("FAIL %s mem past block: got %h want aa", name, dst_mem[DST + OLEN]);
    end
    if (!hold) begin
      bus.start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s return to idle: done=%b busy=%b want 0/0", name, bus.done, bus.busy);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (bus.wr_en !== 1'b0 || bus.load_lfsr !== 1'b0 || bus.lfsr_en !== 1'b0 ||
        bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s controls: got wr=%b ld=%b en=%b done=%b busy=%b want all 0", name,
               bus.wr_en, bus.load_lfsr, bus.lfsr_en, bus.done, bus.busy);
    end
    n_cmp++;
    if (bus.tap_sel !== 3'd0 || bus.pad_ct !== 4'd0 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s status: got tap=%0d pad=%0d err=%b want 0/0/0", name, bus.tap_sel, bus.pad_ct, bus.err);
    end
    n_cmp++;
    if (bus.raddr !== 8'(SRC) || bus.waddr !== 8'(DST)) begin
      n_bad++;
      $display("FAIL %s addresses: got raddr=%0d waddr=%0d want %0d/%0d", name, bus.raddr, bus.waddr, SRC, DST);
    end
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    init_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    build(6'h0A, 2, 0, -1);
    run_pass("basic", 1'b0);
  endtask

  // Reuses the basic message: abort mid-pass, then rerun it
  task automatic test_reset_mid();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.start = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL reset_mid pre-reset wr_en: got %b want 1", bus.wr_en); end
    #2 init_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    bus.start = 1'b0;
    @(negedge clk);
    init_n = 1'b1;
    held_tap = 3'd0;
    @(negedge clk);
    run_pass("reset_rerun", 1'b0);
  endtask

  task automatic test_extra_pads();
    build(6'h0A, 2, 3, -1);
    run_pass("extra_pads", 1'b0);
  endtask

  task automatic test_max_pads();
    build(6'h15, 5, 20, -1);
    run_pass("max_pads", 1'b0);
  endtask

  task automatic test_bad_preamble();
    int tries = 0;
    do begin
      build(6'($urandom_range(1, 63)), 0, 0, $urandom_range(0, 5));
      tries++;
    end while (!exp_err && tries < 64);
    run_pass("bad_preamble", 1'b0);
  endtask

  task automatic test_start_hold();
    int loads;
    build(6'($urandom_range(1, 63)), 3, 1, -1);
    run_pass("hold_pass", 1'b1);
    loads = n_load;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL start_hold cycle %0d: done=%b busy=%b want 1/0", i, bus.done, bus.busy);
      end
    end
    n_cmp++;
    if (n_load !== loads) begin n_bad++; $display("FAIL start_hold reload: got %0d loads want %0d", n_load, loads); end
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL start_hold release: done=%b want 0", bus.done); end
    run_pass("hold_next", 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 6; p++) begin
      build(6'($urandom_range(1, 63)), $urandom_range(0, 5), $urandom_range(0, 18), -1);
      run_pass($sformatf("b2b%0d", p), 1'b0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    init_n = 1'b0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_extra_pads();
    test_max_pads();
    test_bad_preamble();
    test_start_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_decrypt_ctrl.md
Name: lfsr_decrypt_ctrl

Overview:
Sequencing controller for the LFSR stream-decryption datapath: dat_mem plus six parallel lfsr6b instances, one per maximal-length tap pattern 0x21/0x2D/0x30/0x33/0x36/0x39. On a start request it seeds the LFSRs from the first ciphertext symbol and runs them across the preamble. It then identifies which tap pattern produced the keystream and streams decrypted bytes into memory, dropping leading pad characters. The output block is always a fixed length; padding moves to the tail.

Parameters:
SRC_BASE, 64, dat_mem address of the first ciphertext byte
DST_BASE, 0, dat_mem address of the first plaintext byte
MSG_LEN, 64, ciphertext bytes including the preamble; SRC_BASE+MSG_LEN ≤ 256
PRE_LEN, 7, preamble length in symbols; must be ≥ 2
PAD, 8'h5F, pad/preamble plaintext character
KEY, 6'h1F, seed XOR constant (seed = data_out[5:0]^KEY)
MAX_PAD, 15, maximum extra leading pads dropped after the preamble

Ports:
clk  in  1  clock, rising edge
init_n  in  1  asynchronous active-low reset
start  in  1  level request to begin one decrypt pass
data_out  in  8  dat_mem read data, combinational on raddr (same-cycle)
lfsr_state  in  36  six LFSR states; lfsr_state[6i+5:6i] is pattern i
raddr  out  8  dat_mem read address
waddr  out  8  dat_mem write address
wr_en  out  1  dat_mem write enable
data_in  out  8  dat_mem write data
load_lfsr  out  1  load all six LFSRs from start = data_out[5:0]^KEY
lfsr_en  out  1  advance all six LFSRs on the rising clk
tap_sel  out  3  registered index of the matched pattern
pad_ct  out  4  registered count of dropped leading pads
busy  out  1  high in every state except IDLE/DONE
done  out  1  pass complete
err  out  1  preamble did not yield exactly one matching pattern

Behaviour:
- Reset (init_n low, asynchronous): state=IDLE, tap_sel=0, pad_ct=0, err=0, cycle counter c=0, waddr register=DST_BASE. Combinational outputs follow IDLE: raddr=SRC_BASE, wr_en=load_lfsr=lfsr_en=done=busy=0.
- Decryption: dec = data_out ^ {2'b00, lfsr_state[tap_sel]}. data_in = dec in DECRYPT and PAD during FILL.
- IDLE: raddr=SRC_BASE. start=1 → LOAD.
- LOAD (1 cycle): raddr=SRC_BASE, load_lfsr=1; set c=1.
- TRAIN, c=1..PRE_LEN:
  - raddr=SRC_BASE+c-1, lfsr_en=1, c++.
  - At c=PRE_LEN, register match[i] = (lfsr_state[i] == data_out[5:0]^KEY).
  - Exactly one bit set → tap_sel=index, go to DECRYPT.
  - Zero or more than one bit set → err=1, go to DONE. No write occurs in this case.
- DECRYPT, c=PRE_LEN+1..MSG_LEN:
  - raddr=SRC_BASE+c-1, lfsr_en=1, c++.
  - While in skip mode: if dec==PAD and pad_ct<MAX_PAD, then wr_en=0 and pad_ct++.
  - Otherwise leave skip mode permanently. From then on wr_en=1 and waddr advances from DST_BASE by 1 per write; PAD bytes after this point are written as data.
  - After c=MSG_LEN: go to FILL if pad_ct>0, else DONE.
- FILL (pad_ct cycles): wr_en=1, data_in=PAD, waddr continues incrementing, lfsr_en=0 → DONE.
- Output length: writes always total MSG_LEN-PRE_LEN bytes, at DST_BASE..DST_BASE+MSG_LEN-PRE_LEN-1. The exception is err, where the total is 0.
- DONE: done=1, all enables 0. Stay while start=1; start=0 → IDLE.
- start changes while busy are ignored. start already high on entry to IDLE from DONE cannot occur, because DONE waits for start low.
- Reset mid-operation: wr_en drops immediately (asynchronously). Memory contents already written are left as-is. The next start runs a complete, correct pass.
- tap_sel, pad_ct and err hold their values from DONE through IDLE until the next LOAD, which clears pad_ct and err.
- Latency start→done (no err) = 1 + PRE_LEN + (MSG_LEN-PRE_LEN) + pad_ct cycles, then done.
- Address arithmetic is 8-bit. Wrap beyond 255 is illegal by the parameter constraint.

Test Plan:
1. Tap 0x30, seed 0x0A, 7-symbol preamble, no extra pads → tap_sel=2, pad_ct=0, 57 writes to addresses 0..56 equal to the golden plaintext, done at cycle 65 after start.
2. Same stream with 3 extra leading pads → pad_ct=3, first wr_en delayed 3 cycles, plaintext at 0..53, addresses 54..56 = 0x5F, done at cycle 68.
3. 20 extra leading pads, tap 0x39 → tap_sel=5, pad_ct=15, 5 surviving pads written as data at 0..4, addresses 42..56 = 0x5F.
4. Preamble symbol 6 corrupted (bit flip) → err=1, done=1, wr_en never asserted, tap_sel unchanged.
5. init_n pulsed low at cycle 30 of a pass → all outputs 0 within the same cycle; a restart produces results identical to test 1.
6. start held high for 10 cycles after done → done stays 1 with no new LOAD; start low then high → exactly one new pass.
